sc_frog_step_pulser: RTL and testbench
======================================

# sc_frog_step_pulser

Upstream input stage for the frog's vertical position counter: it converts one raw, bouncing, active-low push button into exactly one clean, single-cycle, active-low step pulse per physical press. That pulse drives the counter's increment (load0, active-low) input. The block also suppresses steps when the frog is already on the top row, so the counter never wraps. Placed between the board button pin and the Y position counter, in the 50 MHz domain.

## Interface
- DEBOUNCE_WIDTH, 20: width of the debounce counter.
- DEBOUNCE_COUNT, 1000000: number of consecutive stable samples required (20 ms at 50 MHz). Must be ≥2 and < 2^DEBOUNCE_WIDTH.
- POS_WIDTH, 3: width of the position feedback bus.
- POS_MAX, 7: top row; no step is issued when the position equals this value.
- SC_positionYCOUNTER_CLOCK_50  in  1  system clock, 50 MHz; all state updates on its rising edge.
- SC_positionYCOUNTER_RESET_InHigh  in  1  reset; asynchronous, active-high.
- SC_frogSTEP_button_InLow  in  1  raw button, active-low, asynchronous to the clock, may bounce.
- SC_frogSTEP_enable_InHigh  in  1  game-running qualifier; sampled only at the step decision point.
- SC_frogSTEP_position_InBUS  in  POS_WIDTH  current Y position fed back from the counter.
- SC_frogSTEP_step_OutLow  out  1  one-cycle active-low step pulse; connects to the counter's load0 input.
- SC_frogSTEP_blocked_OutHigh  out  1  high when the last qualified press was suppressed.
- SC_frogSTEP_busy_OutHigh  out  1  high whenever the state is not IDLE.

## Operation
- Synchronizer: two flip-flops, sync1 then sync2, on the button input. Both reset to 1 (button released). All decisions use sync2 only.
- State machine states: IDLE, DEB_PRESS, PULSE, HOLD, DEB_RELEASE. Reset state is IDLE, with the counter cleared.
- IDLE: if sync2 = 0, go to DEB_PRESS and set cnt = 0.
- DEB_PRESS:
  - if sync2 = 1, return to IDLE (bounce rejected) and clear cnt;
  - otherwise, if cnt = DEBOUNCE_COUNT−1, make the decision below;
  - otherwise, cnt += 1.
- Decision (taken on that one edge only):
  - if enable = 1 and position ≠ POS_MAX, go to PULSE and set blocked = 0;
  - otherwise, go to HOLD and set blocked = 1.
- PULSE: step_OutLow = 0. Always go to HOLD on the next edge. The pulse lasts exactly one cycle; there is no autorepeat.
- HOLD: if sync2 = 1, go to DEB_RELEASE and set cnt = 0.
- DEB_RELEASE:
  - if sync2 = 0, return to HOLD (release bounce);
  - if cnt = DEBOUNCE_COUNT−1 and sync2 = 1, go to IDLE;
  - otherwise, cnt += 1.
- Output decode:
  - step_OutLow and busy are decoded from the state register only, so they are glitch-free.
  - blocked is a registered flag. It holds its value until the next decision point.
- Counter: DEBOUNCE_WIDTH bits, unsigned. It never exceeds DEBOUNCE_COUNT−1, so no wrap is possible.
- Position comparison: equality against POS_MAX, zero-extended to POS_WIDTH.

## Timing
- Reset values: step_OutLow = 1, blocked = 0, busy = 0, state = IDLE, cnt = 0, sync1 = sync2 = 1.
- Reset asserted mid-operation, including during PULSE, forces these values immediately. No pulse is emitted after reset is released unless a new full press occurs.
- Press latency. Let edge 1 be the first edge that samples the button low:
  - sync2 goes low at edge 2;
  - DEB_PRESS is entered at edge 3;
  - PULSE is entered at edge 3+DEBOUNCE_COUNT;
  - step_OutLow is low for exactly the one cycle between edges 3+DEBOUNCE_COUNT and 4+DEBOUNCE_COUNT.
- Total press-to-pulse latency: DEBOUNCE_COUNT+3 edges after the first low sample.
- Any high sample of sync2 during DEB_PRESS restarts the debounce from IDLE. The full DEBOUNCE_COUNT low samples are needed again.
- Holding the button produces exactly one pulse, regardless of how long it is held.
- A new press is accepted only after DEBOUNCE_COUNT consecutive high samples in DEB_RELEASE.
- Position and enable are sampled only on the decision edge. Changes at any other time have no effect.
- Position feedback changes one cycle after the pulse, while the block is in HOLD. That change has no effect.

## Test plan
(All with DEBOUNCE_COUNT = 4.)
- Reset: assert reset with button low, then release reset and hold button high for 10 cycles → step stays 1, blocked 0, busy 0 throughout.
- Clean press: button low for 20 cycles, position = 2, enable = 1 → step = 0 exactly during the cycle following edge 7 (counting edge 1 as the first low sample), then 1; exactly one pulse; busy high from edge 3 until edge 6 of the release.
- Bounce: button pattern low 2 cycles, high 1, low 2, high 1, then low 15 → exactly one pulse, occurring 7 edges after the start of the final low run; no pulse from the short runs.
- Top row: position = 7, enable = 1, button held low → no pulse; blocked rises on the decision edge. A later press at position = 3 → one pulse, and blocked returns to 0.
- Disabled: enable = 0 on the decision edge → no pulse, blocked = 1. Enable is toggled while in HOLD → still no pulse.
- Release bounce and reset mid-pulse: bouncing release followed by three quick re-presses shorter than 4 cycles → no extra pulse. Reset asserted during the PULSE cycle → step returns to 1 immediately, and no second pulse follows after reset is released with the button still held.

Source files
------------

// File: rtl/sc_frog_step_pulser.sv
// Debounced one-shot step generator for the frog's Y position counter.
// One clean active-low pulse per physical press; suppressed on the top row or when disabled.
module sc_frog_step_pulser #(
  parameter int unsigned DEBOUNCE_WIDTH = 20,
  parameter int unsigned DEBOUNCE_COUNT = 1000000,
  parameter int unsigned POS_WIDTH      = 3,
  parameter int unsigned POS_MAX        = 7
) (
  input  logic                 SC_positionYCOUNTER_CLOCK_50,
  input  logic                 SC_positionYCOUNTER_RESET_InHigh,
  input  logic                 SC_frogSTEP_button_InLow,
  input  logic                 SC_frogSTEP_enable_InHigh,
  input  logic [POS_WIDTH-1:0] SC_frogSTEP_position_InBUS,
  output logic                 SC_frogSTEP_step_OutLow,
  output logic                 SC_frogSTEP_blocked_OutHigh,
  output logic                 SC_frogSTEP_busy_OutHigh
);

  localparam logic [DEBOUNCE_WIDTH-1:0] CNT_LAST  = DEBOUNCE_WIDTH'(DEBOUNCE_COUNT - 1);
  localparam logic [DEBOUNCE_WIDTH-1:0] CNT_ONE   = DEBOUNCE_WIDTH'(1);
  localparam logic [POS_WIDTH-1:0]      POS_TOP   = POS_WIDTH'(POS_MAX);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    PULSE       = 3'd2,
    HOLD        = 3'd3,
    DEB_RELEASE = 3'd4
  } state_t;

  state_t                    state_q;
  logic [DEBOUNCE_WIDTH-1:0] cnt_q;
  logic                      sync1_q;
  logic                      sync2_q;
  logic                      step_q;
  logic                      blocked_q;
  logic                      busy_q;

  // step and busy are registered alongside the state so they mirror it without decode glitches
  always_ff @(posedge SC_positionYCOUNTER_CLOCK_50 or posedge SC_positionYCOUNTER_RESET_InHigh) begin
    if (SC_positionYCOUNTER_RESET_InHigh) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      step_q    <= 1'b1;
      blocked_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync1_q <= SC_frogSTEP_button_InLow;
      sync2_q <= sync1_q;
      step_q  <= 1'b1;
      case (state_q)
        IDLE: begin
          if (!sync2_q) begin
            state_q <= DEB_PRESS;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        DEB_PRESS: begin
          if (sync2_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            // enable and position only matter on this single decision edge
            if (SC_frogSTEP_enable_InHigh && (SC_frogSTEP_position_InBUS != POS_TOP)) begin
              state_q   <= PULSE;
              blocked_q <= 1'b0;
              step_q    <= 1'b0;
            end else begin
              state_q   <= HOLD;
              blocked_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        PULSE: begin
          state_q <= HOLD;
        end
        HOLD: begin
          if (sync2_q) begin
            state_q <= DEB_RELEASE;
            cnt_q   <= '0;
          end
        end
        DEB_RELEASE: begin
          if (!sync2_q) begin
            state_q <= HOLD;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign SC_frogSTEP_step_OutLow     = step_q;
  assign SC_frogSTEP_blocked_OutHigh = blocked_q;
  assign SC_frogSTEP_busy_OutHigh    = busy_q;

endmodule

// File: tb/tb_sc_frog_step_pulser.sv
// Table-driven bench for sc_frog_step_pulser with DEBOUNCE_COUNT = 4.
// Each record is one clock: inputs applied before the edge, outputs compared 1 ns after it.
module tb_sc_frog_step_pulser;

  localparam int unsigned DW = 20;
  localparam int unsigned DC = 4;
  localparam int unsigned PW = 3;
  localparam int unsigned PM = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn;
  logic          en;
  logic [PW-1:0] pos;
  logic          step;
  logic          blocked;
  logic          busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          btn;
    logic          en;
    logic [PW-1:0] pos;
    logic          step;
    logic          blocked;
    logic          busy;
  } vec_t;

  vec_t vecs[$];

  sc_frog_step_pulser #(
    .DEBOUNCE_WIDTH(DW),
    .DEBOUNCE_COUNT(DC),
    .POS_WIDTH     (PW),
    .POS_MAX       (PM)
  ) dut (
    .SC_positionYCOUNTER_CLOCK_50    (clk),
    .SC_positionYCOUNTER_RESET_InHigh(rst),
    .SC_frogSTEP_button_InLow        (btn),
    .SC_frogSTEP_enable_InHigh       (en),
    .SC_frogSTEP_position_InBUS      (pos),
    .SC_frogSTEP_step_OutLow         (step),
    .SC_frogSTEP_blocked_OutHigh     (blocked),
    .SC_frogSTEP_busy_OutHigh        (busy)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic b, input logic e, input logic [PW-1:0] p,
                              input logic s, input logic bl, input logic bu);
    vec_t v;
    v.btn = b; v.en = e; v.pos = p; v.step = s; v.blocked = bl; v.busy = bu;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic b, input logic e, input logic [PW-1:0] p,
                     input logic s, input logic bl, input logic bu, input string tag);
    btn = b; en = e; pos = p;
    @(posedge clk);
    #1;
    check({tag, " step"}, step, s);
    check({tag, " blocked"}, blocked, bl);
    check({tag, " busy"}, busy, bu);
  endtask

  task automatic cyc_step(input logic b, input string tag);
    btn = b; en = 1'b1; pos = 3'd2;
    @(posedge clk);
    #1;
    check({tag, " step"}, step, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic rb [27];
    rb = '{1,1,0,1,1,0,1,1,1,1,1,1, 0,0,1,1,1, 0,0,1,1,1, 0,0,1,1,1};

    // idle after reset
    for (int i = 1; i <= 10; i++) add(1, 1, 3'd0, 1, 0, 0);
    // clean press at row 2, position feedback moves while holding
    for (int i = 1; i <= 20; i++) add(0, 1, (i >= 8) ? 3'd3 : 3'd2, (i == 7) ? 1'b0 : 1'b1, 0, i >= 3);
    for (int i = 1; i <= 8; i++)  add(1, 1, 3'd3, 1, 0, i < 7);
    // bouncing press: low2 high1 low2 high1 low15
    for (int k = 1; k <= 21; k++)
      add((k == 3 || k == 6), 1, 3'd2, (k == 13) ? 1'b0 : 1'b1, 0,
          (k == 3 || k == 4 || k == 6 || k == 7 || k >= 9));
    for (int i = 1; i <= 8; i++)  add(1, 1, 3'd2, 1, 0, i < 7);
    // top row suppression
    for (int i = 1; i <= 12; i++) add(0, 1, 3'd7, 1, i >= 7, i >= 3);
    for (int i = 1; i <= 8; i++)  add(1, 1, 3'd7, 1, 1, i < 7);
    // later press at row 3 clears blocked
    for (int i = 1; i <= 10; i++) add(0, 1, 3'd3, (i == 7) ? 1'b0 : 1'b1, i < 7, i >= 3);
    for (int i = 1; i <= 8; i++)  add(1, 1, 3'd4, 1, 0, i < 7);
    // disabled at decision, enable toggled during HOLD
    for (int i = 1; i <= 12; i++) add(0, (i > 7) && (i % 2 == 0), 3'd2, 1, i >= 7, i >= 3);
    for (int i = 1; i <= 8; i++)  add(1, 1, 3'd2, 1, 1, i < 7);

    rst = 1'b1; btn = 1'b0; en = 1'b1; pos = 3'd0;
    #2;
    check("reset step", step, 1'b1);
    check("reset blocked", blocked, 1'b0);
    check("reset busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset held step", step, 1'b1);
    check("reset held busy", busy, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) cyc(vecs[i].btn, vecs[i].en, vecs[i].pos,
                          vecs[i].step, vecs[i].blocked, vecs[i].busy, $sformatf("vec%0d", i));

    // press, then bouncing release and three short re-presses: no extra pulse
    for (int i = 1; i <= 10; i++) cyc(0, 1, 3'd2, (i == 7) ? 1'b0 : 1'b1, i < 7, i >= 3, "rb_press");
    for (int i = 0; i < 27; i++) cyc_step(rb[i], $sformatf("rb_bounce%0d", i));
    for (int i = 0; i < 12; i++) cyc_step(1'b1, "rb_settle");
    check("rb final busy", busy, 1'b0);
    check("rb final blocked", blocked, 1'b0);

    // reset asserted during the PULSE cycle
    for (int i = 1; i <= 7; i++) cyc(0, 1, 3'd2, (i == 7) ? 1'b0 : 1'b1, 0, i >= 3, "rp_press");
    #2 rst = 1'b1;
    #1;
    check("rp async step", step, 1'b1);
    check("rp async busy", busy, 1'b0);
    @(posedge clk);
    #1;
    check("rp held step", step, 1'b1);
    rst = 1'b0;
    for (int i = 1; i <= 13; i++)
      cyc((i > 3), 1, 3'd2, 1, 0, (i >= 3 && i <= 5), "rp_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
